// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Arbitrates four byte-wide clients onto one UART transmitter. Each grant
// produces a single write strobe. The arbiter then waits for the
// transmitter's end-of-frame pulse or a timeout. An optional idle gap can
// follow each frame.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_i[3:0]   level request per client, held until its ack
//   req_data_i   client i byte on [8i+7:8i]
//   ack_o[3:0]   one-clock pulse: client byte accepted
//   done_o[3:0]  one-clock pulse: client frame completed
//   err_o        one-clock pulse: tx_done timeout
//   owner_o      current / last granted client
//   busy_o       high whenever the FSM is not idle
//   tx_wrreq_o   write strobe to the transmitter
//   tx_wdata_o   byte to the transmitter
//   tx_rdy_i     transmitter idle flag
//   tx_done_i    transmitter end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for tx_rdy and a request; arbitrates and grants
// ISSUE | write strobe and ack for the granted client (one clock)
// WAIT  | waiting for tx_done, timeout counter running
// GAP   | GAP_CYCLES idle clocks before the next grant
module uart_tx_arb #(
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] req_data_i,
    output logic [3:0]  ack_o,
    output logic [3:0]  done_o,
    output logic        err_o,
    output logic [1:0]  owner_o,
    output logic        busy_o,
    output logic        tx_wrreq_o,
    output logic [7:0]  tx_wdata_o,
    input  logic        tx_rdy_i,
    input  logic        tx_done_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wrreq_q, wrreq_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;

    // Round-robin pick: scan from lowest to highest priority so the
    // last hit (last_q+1) wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wdata_d   = wdata_q;
        wrreq_d   = 1'b0;
        ack_d     = 4'b0000;
        done_d    = 4'b0000;
        err_d     = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (tx_rdy_i && grant_vld) begin
                    state_d            = S_ISSUE;
                    owner_d            = grant_idx;
                    last_d             = grant_idx;
                    wdata_d            = req_data_i[{grant_idx, 3'b000} +: 8];
                    wrreq_d            = 1'b1;
                    ack_d[grant_idx]   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                tmo_cnt_d = 32'd0;
            end
            S_WAIT: begin
                // tx_done takes precedence over a coincident timeout
                if (tx_done_i) begin
                    done_d[owner_q] = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = 32'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            wdata_q   <= 8'h00;
            wrreq_q   <= 1'b0;
            ack_q     <= 4'b0000;
            done_q    <= 4'b0000;
            err_q     <= 1'b0;
            tmo_cnt_q <= 32'd0;
            gap_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wdata_q   <= wdata_d;
            wrreq_q   <= wrreq_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign ack_o      = ack_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign owner_o    = owner_q;
    assign tx_wrreq_o = wrreq_q;
    assign tx_wdata_o = wdata_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        err;
    logic [1:0]  owner;
    logic        busy;
    logic        tx_wrreq;
    logic [7:0]  tx_wdata;
    logic        tx_rdy;
    logic        tx_done;

    uart_tx_arb #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_data_i (req_data),
        .ack_o      (ack),
        .done_o     (done),
        .err_o      (err),
        .owner_o    (owner),
        .busy_o     (busy),
        .tx_wrreq_o (tx_wrreq),
        .tx_wdata_o (tx_wdata),
        .tx_rdy_i   (tx_rdy),
        .tx_done_i  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;
    int   ack_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = last + 2'(k);
            if (r[c]) return c;
        end
        return last;
    endfunction

    // Scoreboard consumer: every write strobe must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ack_cnt += $countones(ack);
                if (tx_wrreq) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_unexpected_wrreq", 32'(tx_wrreq), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_wdata", 32'(tx_wdata), 32'(e.data));
                        check_eq("sb_owner", 32'(owner), 32'(e.own));
                        check_eq("sb_ack", 32'(ack), 32'd1 << e.own);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_wrreq(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_wrreq && n < 60);
        check_eq("wrreq_seen", 32'(tx_wrreq), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_wrreq"}, 32'(tx_wrreq), 32'd0);
        check_eq({pfx, "_wdata"}, 32'(tx_wdata), 32'd0);
        check_eq({pfx, "_ack"},   32'(ack),      32'd0);
        check_eq({pfx, "_done"},  32'(done),     32'd0);
        check_eq({pfx, "_err"},   32'(err),      32'd0);
        check_eq({pfx, "_owner"}, 32'(owner),    32'd0);
        check_eq({pfx, "_busy"},  32'(busy),     32'd0);
    endtask

    initial begin
        int         n;
        int         ord[5];
        logic [1:0] mlast;
        logic [31:0] rd;
        int         wr0, ack0, seen_done;

        rst = 1'b1; req = 4'b0; req_data = 32'h0; tx_rdy = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // tx_done while idle is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check_eq("idle_done_ignored", 32'(done), 32'd0);

        // single client 2
        req_data = 32'h00A5_0000;
        exp_q.push_back('{own: 2'd2, data: 8'hA5});
        tx_rdy = 1'b1;
        req    = 4'b0100;
        wait_wrreq(n);
        check_eq("single_latency", n, 1);
        req = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("single_done", 32'(done), 32'h4);
        check_eq("single_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("single_busy_after_gap", 32'(busy), 32'd0);
        check_eq("single_wdata_held", 32'(tx_wdata), 32'hA5);

        // round-robin with all clients requesting
        do_reset();
        mlast = 2'd3;
        rd = 32'h4433_2211;
        for (int i = 0; i < 5; i++) begin
            ord[i] = rr_pick(4'hF, mlast);
            mlast  = 2'(ord[i]);
            exp_q.push_back('{own: 2'(ord[i]), data: rd[ord[i]*8 +: 8]});
        end
        ack0     = ack_cnt;
        req_data = rd;
        req      = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_wrreq(n);
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            check_eq("rr_done", 32'(done), 32'd1 << ord[i]);
        end
        req = 4'b0;
        wait_idle();
        check_eq("rr_ack_count", ack_cnt - ack0, 5);

        // blocked by tx_rdy=0, then released; frame then times out
        tx_rdy   = 1'b0;
        req_data = 32'h0000_00C3;
        req      = 4'b0001;
        wr0  = wr_cnt;
        ack0 = ack_cnt;
        repeat (10) @(negedge clk);
        check_eq("blocked_wrreq", wr_cnt - wr0, 0);
        check_eq("blocked_ack", ack_cnt - ack0, 0);
        check_eq("blocked_busy", 32'(busy), 32'd0);
        exp_q.push_back('{own: rr_pick(4'b0001, mlast), data: 8'hC3});
        mlast  = 2'd0;
        tx_rdy = 1'b1;
        wait_wrreq(n);
        check_eq("blocked_release_latency", n, 1);
        req = 4'b0;
        n = 0;
        seen_done = 0;
        do begin
            @(negedge clk);
            n++;
            if (done != 4'b0) seen_done = 1;
        end while (!err && n < 60);
        // n counts edges since the ISSUE clock; the first is the WAIT entry
        check_eq("tmo_clocks_after_wait", n - 1, 16);
        check_eq("tmo_no_done", seen_done, 0);
        check_eq("tmo_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("tmo_err_pulse", 32'(err), 32'd0);

        // tx_done on the timeout clock, then gap before next grant
        req_data = 32'h0000_5A00;
        exp_q.push_back('{own: 2'd1, data: 8'h5A});
        req = 4'b0010;
        wait_wrreq(n);
        req_data = 32'h0077_0000;
        req      = 4'b0100;
        exp_q.push_back('{own: 2'd2, data: 8'h77});
        repeat (16) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("coll_done", 32'(done), 32'h2);
        check_eq("coll_err", 32'(err), 32'd0);
        wait_wrreq(n);
        check_eq("gap_done_to_wrreq", n, 4);
        req = 4'b0;
        @(negedge clk);
        check_eq("rstmid_busy_before", 32'(busy), 32'd1);

        // asynchronous reset in WAIT
        #2 rst = 1'b1;
        #1 check_reset_outputs("rstmid");
        @(negedge clk);
        rst = 1'b0;
        req_data = 32'hB300_B100;
        req      = 4'b1010;
        exp_q.push_back('{own: 2'd1, data: 8'hB1});
        seen_done = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (done != 4'b0 || err) seen_done = 1;
        end while (!tx_wrreq && n < 60);
        check_eq("rstmid_no_done_err", seen_done, 0);
        check_eq("rstmid_grant_latency", n, 1);
        req = 4'b0;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("rstmid_done", 32'(done), 32'h2);
        wait_idle();

        check_eq("ack_equals_wrreq", ack_cnt, wr_cnt);
        check_eq("sb_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL provide parameter GAP_CYCLES, default 0: idle clocks inserted after each frame before the next grant.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 2000: maximum clocks to wait for tx_done after a write request; 0 disables the timeout.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  4  level request per client i; held until ack[i].
REQ-007 req_data  in  32  byte for client i on bits [8i+7:8i]; stable while req[i]=1.
REQ-008 ack  out  4  one-clock pulse: byte of client i accepted; client may then change req_data or drop req.
REQ-009 done  out  4  one-clock pulse: frame of client i completed on the line.
REQ-010 err  out  1  one-clock pulse: timeout while waiting for tx_done.
REQ-011 owner  out  2  index of the current or last granted client.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 tx_wrreq  out  1  write strobe to the UART transmitter.
REQ-014 tx_wdata  out  8  byte to the UART transmitter.
REQ-015 tx_rdy  in  1  transmitter idle flag.
REQ-016 tx_done  in  1  transmitter end-of-frame pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and GAP.
REQ-018 IDLE: when tx_rdy=1 and req!=0, SHALL grant one client, register tx_wdata from that client's req_data, set owner, and move to ISSUE; otherwise SHALL remain in IDLE.
REQ-019 Arbitration SHALL be round-robin from pointer last: priority order last+1, last+2, last+3, last (mod 4); last SHALL update to the winner on each grant.
REQ-020 ISSUE: tx_wrreq=1 and ack[owner]=1 for exactly this one clock; the FSM then SHALL move to WAIT.
REQ-021 Grant-to-tx_wrreq latency SHALL be 1 clock.
REQ-022 At most one tx_wrreq SHALL be issued per grant.
REQ-023 tx_wdata SHALL stay constant from ISSUE until the next grant.
REQ-024 WAIT: on tx_done=1, done[owner] SHALL pulse in the following clock, and the FSM SHALL go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-025 WAIT timeout: a 32-bit counter SHALL clear on entry to WAIT and increment each WAIT clock; when it reaches TIMEOUT_CYCLES-1 without tx_done (and TIMEOUT_CYCLES!=0), err SHALL pulse, no done SHALL be issued, and the FSM SHALL go to IDLE.
REQ-026 If tx_done and the timeout occur in the same clock, tx_done SHALL win: done pulses and err does not.
REQ-027 GAP: SHALL count GAP_CYCLES clocks, then return to IDLE.
REQ-028 tx_done received in IDLE, ISSUE or GAP SHALL be ignored.
REQ-029 A req deasserted before grant SHALL be dropped silently.
REQ-030 A req held high after its ack SHALL be treated as a new request and arbitrated fairly.
REQ-031 IDLE with req!=0 but tx_rdy=0 SHALL wait, with no grant and no ack.
REQ-032 ack, done and err SHALL each be one-hot-or-zero and registered.
REQ-033 busy SHALL be combinational from the state.
REQ-034 A back-to-back frame with GAP_CYCLES=0 SHALL be granted no earlier than the clock after done.

Reset
REQ-035 While rst=1, the FSM SHALL be IDLE and the outputs SHALL be: tx_wrreq=0, tx_wdata=0, ack=0, done=0, err=0, owner=0, busy=0; last=3, so client 0 has first priority; the counters SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abort immediately with no done or err pulse; the first grant after release SHALL follow REQ-019 with last=3.

Verification
REQ-037 Single: after reset, req=4'b0100, req_data[23:16]=8'hA5, tx_rdy=1 -> one clock later tx_wrreq=1, tx_wdata=8'hA5, ack=4'b0100; tx_done pulse -> done=4'b0100 next clock, busy=0.
REQ-038 Round-robin: req=4'b1111 held, each frame completed -> grant order 0,1,2,3,0, with exactly one ack per frame.
REQ-039 Blocked: tx_rdy=0, req=4'b0001 for 10 clocks -> no tx_wrreq and no ack; tx_rdy=1 -> grant on the next clock.
REQ-040 Timeout: TIMEOUT_CYCLES=16, tx_done never pulses -> err pulses exactly 16 clocks after entering WAIT, no done, FSM in IDLE.
REQ-041 Gap and collision: GAP_CYCLES=3, tx_done coinciding with the timeout clock -> done pulses, err stays 0, next tx_wrreq no earlier than 3 clocks after done.
REQ-042 Reset mid-WAIT: rst pulsed -> all outputs at REQ-035 values within the same clock, no done, next grant goes to the lowest requesting index.
